des_key_sequencer: RTL and testbench
====================================

Name: des_key_sequencer

Overview:
- Iterative DES key schedule. Emits the 16 round keys one per handshake, so the full 16x48 key array never needs to be stored.
- Encrypt mode emits K1..K16 using left rotations.
- Decrypt mode emits K16..K1 directly, using right rotations. This is the on-the-fly counterpart to array-reversal of a precomputed schedule.
- Sits between the 64-bit key register and the iterative DES/3DES round datapath.

Parameters:
- NUM_ROUNDS, 16, rounds per key schedule. Fixed by DES; exposed only for the bench.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  load key and begin a schedule. Sampled only in IDLE.
- decrypt  input  1  0 = forward order (K1 first), 1 = reverse order (K16 first). Sampled with start.
- key  input  [0:63]  DES key. Bit 0 = DES bit 1. Parity bits are ignored.
- round_key_ready  input  1  consumer accepts round_key this cycle.
- round_key  output  [0:47]  current round key, PC-2 of the C/D registers.
- round_key_valid  output  1  round_key is valid.
- round_idx  output  [3:0]  DES key number minus 1 of the current round_key (0 = K1, 15 = K16).
- busy  output  1  schedule in progress.
- done  output  1  one-cycle pulse after the last key is accepted.

Behaviour:
- Reset (async, any state): state=IDLE; C, D, counter, round_key, round_idx = 0; valid, busy, done = 0. Reset mid-schedule aborts it with no done pulse.
- Shift table SH[0..15] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Rotations are within each 28-bit half.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - round_key = 0, valid = 0.
  - On start: apply PC-1 to key, giving C0/D0, and go to RUN.
  - Encrypt: C,D <= rotl(C0/D0, SH[0]); round_idx <= 0.
  - Decrypt: C,D <= C0/D0 (total rotation 28 = identity, i.e. C16); round_idx <= 15.
  - busy=1 from the cycle after start. The first valid key appears the cycle after start (latency 1).
- RUN:
  - valid = 1. round_key = PC-2(C,D), combinational from registers.
  - While valid && !ready, round_key, round_idx, C and D hold stable.
  - On a valid && ready handshake with j keys already accepted (j < 15):
    - Encrypt: C,D <= rotl(C,D, SH[j+1]); round_idx++.
    - Decrypt: C,D <= rotr(C,D, SH[15-j]); round_idx--.
  - On the handshake of the 16th key: go to FIN; valid drops the next cycle.
- FIN: done = 1 for exactly one cycle; busy=0, valid=0; return to IDLE. start is ignored in FIN; it is accepted again from IDLE the following cycle.
- start asserted while busy (RUN/FIN) is ignored. key and decrypt are not re-sampled.
- ready asserted while valid=0 has no effect.
- Back-to-back: with ready held high, the 16 keys occupy 16 consecutive cycles. done follows on cycle 17 after start+1.
- After the last rotation, C/D return to C0/D0 rotated by 28 in the forward case, which is expected. Registers are cleared to 0 on leaving FIN.

Decomposition:
- Shared package des_pkg:
  - PC1 and PC2 permutation tables.
  - SH shift table.
  - des_key_t [0:63], round_key_t [0:47] and half_key_t [0:27] typedefs.
  - enum {IDLE, RUN, FIN} for the FSM.
- One combinational sub-module, des_pc2 (56 -> 48 permutation). It is reused by the full-array schedule generator.
- PC-1 and the rotations stay inline.

Test Plan:
- Forward vector: key=0x133457799BBCDFF1, decrypt=0, ready=1 -> keys appear on cycles 1..16 with round_idx 0..15. K1=0x1B02EFFC7072, K16=0xCB3D8B0E17F5; done pulses on cycle 17.
- Reverse vector: same key, decrypt=1, ready=1 -> first key 0xCB3D8B0E17F5 (round_idx=15), last key 0x1B02EFFC7072 (round_idx=0). The full sequence equals the forward sequence reversed.
- Backpressure: ready randomly deasserted (~50%) -> round_key and round_idx are stable whenever valid && !ready, no key is skipped or duplicated, and exactly 16 handshakes occur before done.
- Start while busy: pulse start with a different key and decrypt at round 5 -> the sequence continues unchanged with the original key; done fires once.
- Reset mid-operation: assert rst asynchronously at round 7 -> outputs zero immediately with no done pulse. A new start afterwards produces a correct full sequence from K1 (or K16).
- Parity insensitivity: key=0x133457799BBCDFF1 with every parity bit flipped (XOR 0x0101010101010101) -> identical 16 keys.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES key-schedule types, tables and helpers.
// Bit 0 of every [0:N] vector is DES bit 1.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef logic [0:63] des_key_t;
  typedef logic [0:55] cd_key_t;
  typedef logic [0:47] round_key_t;
  typedef logic [0:27] half_key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int SH [16] = '{
    1, 1, 2, 2, 2, 2, 2, 2,
    1, 2, 2, 2, 2, 2, 2, 1
  };

  function automatic cd_key_t pc1(input des_key_t k);
    cd_key_t r;
    for (int i = 0; i < 56; i++) r[i] = k[PC1[i]-1];
    return r;
  endfunction

  function automatic half_key_t rotl(input half_key_t h, input int n);
    half_key_t r;
    for (int i = 0; i < 28; i++) r[i] = h[(i + n) % 28];
    return r;
  endfunction

  function automatic half_key_t rotr(input half_key_t h, input int n);
    half_key_t r;
    for (int i = 0; i < 28; i++) r[i] = h[(i + 28 - n) % 28];
    return r;
  endfunction

endpackage

// File: rtl/des_key_sequencer_pc2.sv
// DES PC-2 compression permutation, 56-bit C/D to 48-bit round key.
// Purely combinational; shared with the full-array schedule generator.
module des_pc2
  import des_pkg::*;
(
  input  logic [0:55] cd,
  output logic [0:47] round_key
);

  // Select each round-key bit from its PC-2 source position.
  always_comb begin
    round_key = '0;
    for (int i = 0; i < 48; i++) round_key[i] = cd[PC2[i]-1];
  end

endmodule

// File: rtl/des_key_sequencer.sv
// Iterative DES key schedule, one round key per valid/ready handshake.
// Decrypt order is produced directly with right rotations from C16 = C0.
module des_key_sequencer
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        decrypt,
  input  logic [0:63] key,
  input  logic        round_key_ready,
  output logic [0:47] round_key,
  output logic        round_key_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  state_t     state;
  half_key_t  c;
  half_key_t  d;
  half_key_t  c0;
  half_key_t  d0;
  cd_key_t    cd0;
  logic [3:0] cnt;
  logic [3:0] idx;
  logic       dec;
  round_key_t pc2_out;

  des_pc2 u_pc2 (
    .cd        ({c, d}),
    .round_key (pc2_out)
  );

  // Split the PC-1 image of the incoming key into its two halves.
  always_comb begin
    cd0 = pc1(key);
    c0  = cd0[0:27];
    d0  = cd0[28:55];
  end

  assign round_key_valid = (state == RUN);
  assign busy            = (state == RUN);
  assign done            = (state == FIN);
  assign round_idx       = idx;
  assign round_key       = round_key_valid ? pc2_out : '0;

  // Schedule FSM: load on start, step C/D on each accepted key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      c     <= '0;
      d     <= '0;
      cnt   <= '0;
      idx   <= '0;
      dec   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dec   <= decrypt;
            cnt   <= '0;
            state <= RUN;
            if (decrypt) begin
              c   <= c0;
              d   <= d0;
              idx <= LAST;
            end else begin
              c   <= rotl(c0, SH[0]);
              d   <= rotl(d0, SH[0]);
              idx <= '0;
            end
          end
        end
        RUN: begin
          if (round_key_ready) begin
            if (cnt == LAST) begin
              state <= FIN;
            end else begin
              cnt <= cnt + 4'd1;
              if (dec) begin
                c   <= rotr(c, SH[15 - int'(cnt)]);
                d   <= rotr(d, SH[15 - int'(cnt)]);
                idx <= idx - 4'd1;
              end else begin
                c   <= rotl(c, SH[int'(cnt) + 1]);
                d   <= rotl(d, SH[int'(cnt) + 1]);
                idx <= idx + 4'd1;
              end
            end
          end
        end
        FIN: begin
          state <= IDLE;
          c     <= '0;
          d     <= '0;
          cnt   <= '0;
          idx   <= '0;
          dec   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_sequencer.sv
// Scoreboard bench for des_key_sequencer with a cumulative-shift key model.
// Stimulus pushes expected keys; a negedge monitor pops and compares.
module tb_des_key_sequencer;

  localparam logic [63:0] KEY  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PAR  = 64'h0101010101010101;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  localparam int TPC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int TPC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int TSH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef struct {
    logic [47:0] k;
    logic [3:0]  i;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        decrypt;
  logic [0:63] key_in;
  logic        ready;
  logic [0:47] round_key;
  logic        valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  exp_t        exp_q [$];
  logic [47:0] obs_q [$];
  logic [47:0] fwd [16];

  logic        prev_stall = 1'b0;
  logic [47:0] prev_key;
  logic [3:0]  prev_idx;

  des_key_sequencer #(.NUM_ROUNDS(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .decrypt         (decrypt),
    .key             (key_in),
    .round_key_ready (ready),
    .round_key       (round_key),
    .round_key_valid (valid),
    .round_idx       (round_idx),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [27:0] rot28(input logic [27:0] x, input int s);
    int m;
    m = s % 28;
    if (m == 0) return x;
    return (x << m) | (x >> (28 - m));
  endfunction

  // Forward schedule: Kr = PC2(C0,D0 rotated left by sum of shifts).
  task automatic build_model(input logic [63:0] k);
    logic [55:0] pk;
    logic [55:0] cd;
    int tot;
    for (int i = 0; i < 56; i++) pk[55-i] = k[64-TPC1[i]];
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += TSH[r];
      cd = {rot28(pk[55:28], tot), rot28(pk[27:0], tot)};
      for (int i = 0; i < 48; i++) fwd[r][47-i] = cd[56-TPC2[i]];
    end
  endtask

  // Monitor: scoreboard pops, hold-stability and done counting.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && valid) begin
        chk("stable_key", round_key, prev_key);
        chk("stable_idx", round_idx, prev_idx);
      end
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_key");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("round_key", round_key, e.k);
          chk("round_idx", round_idx, e.i);
        end
        obs_q.push_back(round_key);
        hs_cnt++;
      end
      if (done) done_cnt++;
      prev_stall = valid && !ready;
      prev_key   = round_key;
      prev_idx   = round_idx;
    end
  end

  // mode 0: ready=1, 1: random ready, 2: start while busy, 3: reset at round 7
  task automatic run(input logic [63:0] k, input logic [63:0] mk,
                     input bit dec, input int mode);
    int base_hs;
    int base_done;
    int k_done;
    bit pulsed;
    bit aborted;
    build_model(mk);
    for (int r = 0; r < 16; r++) begin
      exp_t e;
      e.i = dec ? 4'(15 - r) : 4'(r);
      e.k = fwd[e.i];
      exp_q.push_back(e);
    end
    obs_q.delete();
    base_hs   = hs_cnt;
    base_done = done_cnt;
    k_done    = 0;
    pulsed    = 0;
    aborted   = 0;
    @(posedge clk); #1;
    key_in  = k;
    decrypt = dec;
    start   = 1'b1;
    ready   = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (done) begin
        k_done = cyc;
        break;
      end
      @(posedge clk); #1;
      ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      if (mode == 2 && !pulsed && hs_cnt - base_hs == 5) begin
        start   = 1'b1;
        key_in  = ~k;
        decrypt = ~dec;
        pulsed  = 1;
      end
      if (mode == 3 && hs_cnt - base_hs == 7) begin
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", valid, 0);
        chk("rst_key", round_key, 0);
        chk("rst_idx", round_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        aborted = 1;
        break;
      end
    end
    start = 1'b0;
    if (aborted) begin
      exp_q.delete();
      repeat (3) @(posedge clk);
      chk("no_done_after_reset", done_cnt - base_done, 0);
    end else begin
      if (k_done == 0) begin
        fail("timeout_waiting_done");
      end else begin
        chk("valid_at_done", valid, 0);
        chk("busy_at_done", busy, 0);
        if (mode == 0) chk("done_latency", k_done, 17);
      end
      repeat (3) @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);
      chk("handshakes", hs_cnt - base_hs, 16);
      chk("done_once", done_cnt - base_done, 1);
      exp_q.delete();
    end
  endtask

  task automatic check_ends(input logic [47:0] first, input logic [47:0] last);
    if (obs_q.size() != 16) begin
      fail("observed_count");
    end else begin
      chk("first_key", obs_q[0], first);
      chk("last_key", obs_q[15], last);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    decrypt = 1'b0;
    key_in  = '0;
    ready   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_key", round_key, 0);
    chk("reset_idx", round_idx, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run(KEY, KEY, 0, 0);
    check_ends(K1, K16);
    run(KEY, KEY, 1, 0);
    check_ends(K16, K1);
    run(KEY, KEY, 0, 1);
    run(KEY, KEY, 1, 1);
    run(KEY, KEY, 0, 2);
    run(KEY, KEY, 1, 2);
    run(KEY, KEY, 0, 3);
    run(KEY, KEY, 0, 0);
    check_ends(K1, K16);
    run(KEY, KEY, 1, 3);
    run(KEY, KEY, 1, 1);
    run(KEY ^ PAR, KEY, 0, 1);
    run(KEY ^ PAR, KEY, 1, 0);
    check_ends(K16, K1);
    for (int n = 0; n < 6; n++) begin
      logic [63:0] rk;
      rk = {$urandom, $urandom};
      run(rk, rk, 1'($urandom_range(0, 1)), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
